uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte producers. It latches the winning requester's byte and launches a frame with a single-cycle `tx_val` pulse. That rising edge also restarts the baud generator phase. It then waits for the transmitter's end-of-frame pulse, enforces an inter-frame gap, and recovers from a stuck transmitter with a watchdog. It sits between the on-chip message sources and the UART_Tx/baudgen pair.

---
 rtl/uart_tx_sched.sv | 137 +++++++++++++
 tb/tb_uart_tx_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among
// NUM_REQ byte producers. One byte per frame: latch the winner's byte,
// acknowledge it, pulse tx_val, wait for tx_done (guarded by a watchdog),
// then hold off for GAP_CYCLES before the next arbitration.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   req          per-requester level request, held with data until ack
//   req_data     byte of requester i on [i*DATA_W +: DATA_W]
//   req_last     1 = byte ends packet, 0 = keep grant locked to requester
//   ack          one-hot, one-cycle pulse when a requester's byte is latched
//   tx_val       one-cycle launch pulse to UART_Tx/baudgen
//   tx_data      latched byte
//   tx_done      end-of-frame pulse from the transmitter
//   grant_id     current / last granted requester
//   busy         high whenever the scheduler is not idle
//   timeout_err  one-cycle pulse when the watchdog expires
module uart_tx_sched #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int IDW            = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_val,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  // One counter serves both the watchdog (WAIT) and the gap (GAP).
  localparam int CMAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP} state_t;

  state_t state, state_nx;

  logic [NUM_REQ-1:0][DATA_W-1:0] data_arr;
  logic [NUM_REQ-1:0] elig;
  logic [IDW-1:0]     rr_ptr, win_id, lock_id;
  logic               win_vld, lock, last_q, wd_exp;
  logic [CW-1:0]      cnt;

  assign data_arr = req_data;

  // While a packet is in progress only its owner may be granted.
  always_comb begin
    elig = req;
    if (lock) elig = req & (NUM_REQ'(1) << lock_id);
  end

  // First eligible requester after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = rr_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_nx = state;
    wd_exp   = 1'b0;
    case (state)
      S_IDLE: if (win_vld) state_nx = S_LOAD;
      S_LOAD: state_nx = S_SEND;
      S_SEND: state_nx = S_WAIT;
      S_WAIT: begin
        // tx_done on the expiry cycle wins over the watchdog
        if (TIMEOUT_CYCLES > 0 && !tx_done && cnt == TO_LAST) wd_exp = 1'b1;
        if (tx_done || wd_exp) state_nx = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      end
      S_GAP:  if (cnt == GAP_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ack         <= '0;
      tx_val      <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= IDW'(NUM_REQ - 1);
      lock        <= 1'b0;
      lock_id     <= '0;
      last_q      <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nx;
      // outputs are registered off the next state so they line up with it
      ack         <= '0;
      tx_val      <= (state == S_LOAD);
      busy        <= (state_nx != S_IDLE);
      timeout_err <= wd_exp;

      if (state == S_IDLE && win_vld) begin
        ack      <= NUM_REQ'(1) << win_id;
        tx_data  <= data_arr[win_id];
        last_q   <= req_last[win_id];
        grant_id <= win_id;
        rr_ptr   <= win_id;
      end

      if (state == S_LOAD) begin
        lock    <= ~last_q;
        lock_id <= grant_id;
      end
      if (wd_exp) lock <= 1'b0;

      if (state_nx != state)                   cnt <= '0;
      else if (state == S_WAIT || state == S_GAP) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a timeline model predicts every output each cycle
// from the grant edge, the tx_done/timeout edge and the gap length; directed
// scenarios add hand-computed latency and grant-order expectations.
module tb_uart_tx_sched;
  localparam int N = 4, W = 8, G = 16, T = 50, IDW = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0]   req = '0, req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic           tx_done;
  logic [N-1:0]   ack;
  logic           tx_val, busy, timeout_err;
  logic [W-1:0]   tx_data;
  logic [IDW-1:0] grant_id;
  logic           resp_done = 1'b0, stray_done = 1'b0;

  assign tx_done = resp_done | stray_done;
  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .tx_val(tx_val), .tx_data(tx_data), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  int cyc = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] el, input int ptr);
    for (int k = 1; k <= N; k++) if (el[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Timeline model. Edge numbers: grant at t0, LOAD ends t0+1, SEND ends
  // t0+2, watchdog cycle k ends at t0+3+k, IDLE is entered G edges after done.
  bit         m_act = 0, m_last = 0, m_lock = 0;
  int         m_t0 = -10, m_end = -1, m_idle = -1, m_to = -10;
  int         m_g = 0, m_rr = N - 1, m_lid = 0;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] e_ack = '0;
  bit         e_val = 0, e_busy = 0, e_to = 0;

  always @(posedge clk or negedge rst) begin : model
    int n, w;
    logic [N-1:0] el;
    if (!rst) begin
      m_act = 0; m_last = 0; m_lock = 0; m_t0 = -10; m_end = -1; m_idle = -1;
      m_to = -10; m_g = 0; m_rr = N - 1; m_lid = 0; m_data = '0;
      e_ack = '0; e_val = 0; e_busy = 0; e_to = 0;
    end else begin
      cyc++;
      n = cyc;
      if (m_act) begin
        if (n == m_t0 + 1) begin m_lock = !m_last; m_lid = m_g; end
        if (n >= m_t0 + 3 && m_end < 0) begin
          if (tx_done) m_end = n;
          else if (n - (m_t0 + 3) == T - 1) begin m_end = n; m_to = n; m_lock = 0; end
          if (m_end >= 0) m_idle = m_end + G;
        end
        if (n == m_idle) m_act = 0;
      end else begin
        el = m_lock ? (req & (N'(1) << m_lid)) : req;
        w  = pick(el, m_rr);
        if (w >= 0) begin
          m_act = 1; m_t0 = n; m_g = w; m_rr = w;
          m_data = req_data[w*W +: W]; m_last = req_last[w];
          m_end = -1; m_idle = -1;
        end
      end
      e_ack  = (m_act && n == m_t0) ? (N'(1) << m_g) : '0;
      e_val  = m_act && n == m_t0 + 1;
      e_busy = m_act;
      e_to   = (n == m_to);
    end
  end

  always @(negedge clk) begin
    chk("ack", ack, e_ack);
    chk("tx_val", tx_val, e_val);
    chk("busy", busy, e_busy);
    chk("timeout_err", timeout_err, e_to);
    chk("grant_id", grant_id, m_g);
    chk("tx_data", tx_data, m_data);
  end

  // transmitter stand-in: tx_done driven dly cycles after the tx_val cycle
  int dly = 20, pend = -1;
  always @(negedge clk) begin
    if (!rst) begin pend = -1; resp_done = 0; end
    else begin
      resp_done = (cyc == pend);
      if (tx_val && dly > 0) pend = cyc + dly;
    end
  end

  int grants[$];
  int n_to = 0;
  always @(negedge clk) begin
    if (rst && timeout_err) n_to++;
    if (rst && ack != '0) for (int i = 0; i < N; i++) if (ack[i]) grants.push_back(i);
  end

  // sel: 0 ack, 1 tx_val, 2 busy low, 3 timeout_err
  task automatic wait_for(input int sel, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((sel == 0 && ack != '0) || (sel == 1 && tx_val) ||
          (sel == 2 && !busy) || (sel == 3 && timeout_err)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_bound: event %0d not seen within %0d cycles", sel, bound);
    end
  endtask

  task automatic chk_grants(input string nm, input int exp[$]);
    chk({nm, "_count"}, grants.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grants.size(); i++) chk(nm, grants[i], exp[i]);
  endtask

  initial begin : stim
    int c0, ca, cv, cb, ct, k0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_tx_val", tx_val, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b1;

    // round robin, all requesting
    @(negedge clk);
    grants.delete(); dly = 3;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req_last = 4'hF; req = 4'hF;
    for (int i = 0; i < 400 && grants.size() < 5; i++) @(negedge clk);
    req = '0;
    wait_for(2, 100, cb);
    chk_grants("rr_order", '{0, 1, 2, 3, 0});

    // single requester
    grants.delete(); dly = 20;
    req_data[2*W +: W] = 8'hA5; req_last = 4'b0100; req = 4'b0100; c0 = cyc;
    wait_for(0, 10, ca);
    chk("single_ack_lat", ca - c0, 1);
    chk("single_ack", ack, 4'b0100);
    req = '0;
    wait_for(1, 10, cv);
    chk("single_val_lat", cv - c0, 2);
    chk("single_data", tx_data, 8'hA5);
    wait_for(2, 200, cb);
    chk("single_busy_fall", cb - cv, 37);

    // packet lock: three bytes from req0 while req1 waits
    grants.delete(); dly = 4; k0 = 0;
    req_data[0 +: W] = 8'hB0; req_data[W +: W] = 8'hC1; req_last = 4'b0010; req = 4'b0011;
    for (int i = 0; i < 400 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (ack[0]) begin
        k0++;
        case (k0)
          1: req_data[0 +: W] = 8'hB1;
          2: begin req_data[0 +: W] = 8'hB2; req_last[0] = 1'b1; end
          default: req[0] = 1'b0;
        endcase
      end
      if (ack[1]) req[1] = 1'b0;
    end
    wait_for(2, 200, cb);
    chk_grants("lock_order", '{0, 0, 0, 1});

    // watchdog with lock held; tx_done never returned
    grants.delete(); dly = 0;
    req_data[0 +: W] = 8'hD0; req_last = 4'b0010; req = 4'b0011;
    wait_for(1, 20, cv);
    wait_for(3, 100, ct);
    chk("wd_latency", ct - cv, 51);
    req[0] = 1'b0;
    wait_for(0, 40, ca);
    chk("wd_next_grant", ack, 4'b0010);
    dly = 5; req[1] = 1'b0;
    wait_for(2, 200, cb);
    chk_grants("wd_order", '{0, 1});

    // tx_done on the expiry cycle, stray tx_done in GAP and IDLE
    dly = 50; n_to = 0;
    req_data[2*W +: W] = 8'h3C; req_last = 4'b0100; req = 4'b0100;
    wait_for(0, 10, ca);
    req = '0;
    wait_for(1, 10, cv);
    repeat (55) @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    wait_for(2, 100, cb);
    chk("edge_busy_fall", cb - cv, 67);
    chk("edge_no_timeout", n_to, 0);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_val", tx_val, 0);

    // reset in the middle of WAIT_DONE
    dly = 0;
    req_data[3*W +: W] = 8'h77; req_last = 4'b1000; req = 4'b1000;
    wait_for(1, 10, cv);
    req = '0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ack", ack, 0);
    chk("arst_tx_val", tx_val, 0);
    chk("arst_timeout", timeout_err, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_data", tx_data, 0);
    @(negedge clk);
    rst = 1'b1;
    req_data[0 +: W] = 8'h5A; req_last = 4'b0001; req = 4'b0001; dly = 4; c0 = cyc;
    wait_for(0, 10, ca);
    chk("post_rst_ack_lat", ca - c0, 1);
    chk("post_rst_ack", ack, 4'b0001);
    req = '0;
    wait_for(1, 10, cv);
    chk("post_rst_val_lat", cv - c0, 2);
    chk("post_rst_data", tx_data, 8'h5A);
    wait_for(2, 100, cb);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not complete");
    $fatal(1);
  end

endmodule
